// File: rtl/mod_addsub_pipe_if.sv
// Operand/result handshake bundle for the modular add/subtract pipeline.
// Signal names carry the direction as seen from the pipeline (slave side).
interface mod_addsub_pipe_if #(
  parameter int WIDTH = 23
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic             op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH-1:0] q_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] c_o;
  logic             err_o;

  // Producer of operands and consumer of results
  modport master (
    output in_valid_i, op_i, a_i, b_i, q_i, out_ready_i,
    input  in_ready_o, out_valid_o, c_o, err_o
  );

  // The pipeline itself
  modport slave (
    input  in_valid_i, op_i, a_i, b_i, q_i, out_ready_i,
    output in_ready_o, out_valid_o, c_o, err_o
  );
endinterface

// File: rtl/mod_addsub_pipe.sv
// Two-stage modular add/subtract pipeline with valid/ready flow control.
// Stage 1 forms the raw (WIDTH+1)-bit sum or difference and range-checks the
// operands; stage 2 folds the raw value back into [0, q) and drives the
// output register. The modulus and opcode ride along with each beat.
module mod_addsub_pipe #(
  parameter int WIDTH = 23
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mod_addsub_pipe_if.slave bus
);

  // Folds a raw stage-1 value into the modulus range. Add: subtract q once if
  // the sum reached q. Subtract: add q back (mod 2^WIDTH) if a borrow occurred.
  // Out-of-range operands still go through the same formula, truncated.
  function automatic logic [WIDTH-1:0] mod_correct(
    input logic             op,
    input logic [WIDTH:0]   raw,
    input logic             borrow,
    input logic [WIDTH-1:0] q
  );
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   reduced;
    logic [WIDTH-1:0] res;
    q_ext   = {1'b0, q};
    reduced = raw - q_ext;
    res     = raw[WIDTH-1:0];
    if (op) begin
      if (borrow) begin
        res = raw[WIDTH-1:0] + q;
      end
    end else begin
      if (raw >= q_ext) begin
        res = reduced[WIDTH-1:0];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------
  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic adv_p1, adv_p2;
  logic accept;

  // Each stage may take new contents when empty or when its current beat
  // leaves this cycle; stage 1 readiness is combinational from out_ready_i.
  assign adv_p2 = ~vld_p2_q | bus.out_ready_i;
  assign adv_p1 = ~vld_p1_q | adv_p2;
  assign accept = bus.in_valid_i & adv_p1 & ~rst_i;

  // ---------------------------------------------------------------------
  // Stage 1: raw sum/difference, borrow, operand range check
  // ---------------------------------------------------------------------
  logic [WIDTH:0]        sum_w;
  logic signed [WIDTH:0] diff_w;
  logic [WIDTH:0]        raw_p1_q, raw_p1_d;
  logic                  borrow_p1_q, borrow_p1_d;
  logic                  op_p1_q, op_p1_d;
  logic [WIDTH-1:0]      q_p1_q, q_p1_d;
  logic                  err_p1_q, err_p1_d;

  // Stage-1 next state: valid follows acceptance, data loads only on accept.
  always_comb begin
    sum_w       = {1'b0, bus.a_i} + {1'b0, bus.b_i};
    diff_w      = $signed({1'b0, bus.a_i}) - $signed({1'b0, bus.b_i});
    vld_p1_d    = vld_p1_q;
    raw_p1_d    = raw_p1_q;
    borrow_p1_d = borrow_p1_q;
    op_p1_d     = op_p1_q;
    q_p1_d      = q_p1_q;
    err_p1_d    = err_p1_q;
    if (adv_p1) begin
      vld_p1_d = accept;
    end
    if (accept) begin
      op_p1_d     = bus.op_i;
      q_p1_d      = bus.q_i;
      err_p1_d    = (bus.a_i >= bus.q_i) | (bus.b_i >= bus.q_i);
      raw_p1_d    = bus.op_i ? $unsigned(diff_w) : sum_w;
      borrow_p1_d = bus.op_i & diff_w[WIDTH];
    end
  end

  // Stage-1 occupancy flag, cleared asynchronously so in-flight beats vanish.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
    end
  end

  // Stage-1 payload; never observed while its valid flag is low.
  always_ff @(posedge clk_i) begin
    raw_p1_q    <= raw_p1_d;
    borrow_p1_q <= borrow_p1_d;
    op_p1_q     <= op_p1_d;
    q_p1_q      <= q_p1_d;
    err_p1_q    <= err_p1_d;
  end

  // ---------------------------------------------------------------------
  // Stage 2: conditional correction into the output register
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] c_p2_q, c_p2_d;
  logic             err_p2_q, err_p2_d;

  // Stage-2 next state: results hold while the consumer stalls.
  always_comb begin
    vld_p2_d = vld_p2_q;
    c_p2_d   = c_p2_q;
    err_p2_d = err_p2_q;
    if (adv_p2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        c_p2_d   = mod_correct(op_p1_q, raw_p1_q, borrow_p1_q, q_p1_q);
        err_p2_d = err_p1_q;
      end
    end
  end

  // Output register; cleared on reset so the result bus reads zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p2_q <= 1'b0;
      c_p2_q   <= '0;
      err_p2_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p2_d;
      c_p2_q   <= c_p2_d;
      err_p2_q <= err_p2_d;
    end
  end

  assign bus.in_ready_o  = adv_p1 & ~rst_i;
  assign bus.out_valid_o = vld_p2_q;
  assign bus.c_o         = c_p2_q;
  assign bus.err_o       = err_p2_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed bench for mod_addsub_pipe: hand-computed vectors, scoreboard of
// expected results in acceptance order, occupancy model for in_ready_o.
module tb_mod_addsub_pipe;
  localparam int W = 23;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mod_addsub_pipe_if #(.WIDTH(W)) bus ();

  mod_addsub_pipe #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int occ    = 0;
  bit lat_chk = 1'b1;

  logic [W-1:0] exp_c_q[$];
  logic         exp_e_q[$];
  int           exp_t_q[$];
  logic [W-1:0] cur_c;
  logic         cur_e;

  bit           held_v = 1'b0;
  logic [W-1:0] held_c;
  logic         held_e;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] ec, input logic ee);
    bus.in_valid_i = 1'b1;
    bus.op_i = op;
    bus.a_i  = a;
    bus.b_i  = b;
    bus.q_i  = q;
    cur_c    = ec;
    cur_e    = ee;
  endtask

  task automatic idle();
    bus.in_valid_i = 1'b0;
    bus.op_i = 1'b1;
    bus.a_i  = 23'h5A5A5;
    bus.b_i  = 23'h12345;
    bus.q_i  = 23'd7;
  endtask

  // One clock: sample just before the edge, score transfers, advance.
  task automatic step(output bit acc);
    bit oxf;
    bit exp_rdy;
    logic [W-1:0] oc;
    logic oe;
    logic [W-1:0] ec;
    logic ee;
    int t;
    #1;
    exp_rdy = (occ < 2) || bus.out_ready_i;
    chk("in_ready", {22'd0, bus.in_ready_o}, {22'd0, exp_rdy});
    oxf = bus.out_valid_o & bus.out_ready_i;
    acc = bus.in_valid_i & bus.in_ready_o;
    oc  = bus.c_o;
    oe  = bus.err_o;
    if (held_v && bus.out_valid_o) begin
      chk("hold_c", oc, held_c);
      chk("hold_err", {22'd0, oe}, {22'd0, held_e});
    end
    held_v = bus.out_valid_o & ~bus.out_ready_i;
    held_c = oc;
    held_e = oe;
    if (oxf) begin
      checks++;
      assert (exp_c_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out: observed c=%0d expected no result", oc);
      end
      if (exp_c_q.size() != 0) begin
        ec = exp_c_q.pop_front();
        ee = exp_e_q.pop_front();
        t  = exp_t_q.pop_front();
        chk("c", oc, ec);
        chk("err", {22'd0, oe}, {22'd0, ee});
        if (lat_chk) chk("latency", W'(cyc - t), W'(2));
      end
    end
    if (acc) begin
      exp_c_q.push_back(cur_c);
      exp_e_q.push_back(cur_e);
      exp_t_q.push_back(cyc);
    end
    occ = occ + (acc ? 1 : 0) - (oxf ? 1 : 0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [W-1:0] ec, input logic ee);
    bit acc;
    int n;
    set_beat(op, a, b, q, ec, ee);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      step(acc);
      n++;
    end
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL send_timeout: observed not accepted expected accepted");
    end
    idle();
  endtask

  task automatic drain();
    bit acc;
    int n;
    idle();
    bus.out_ready_i = 1'b1;
    n = 0;
    while (exp_c_q.size() != 0 && n < 10) begin
      step(acc);
      n++;
    end
    checks++;
    assert (exp_c_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d pending expected 0", exp_c_q.size());
    end
  endtask

  logic [W-1:0] bp_a [5] = '{23'd1, 23'd5, 23'd30, 23'd7, 23'd39};
  logic [W-1:0] bp_b [5] = '{23'd2, 23'd6, 23'd30, 23'd8, 23'd1};
  logic         bp_op[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] bp_c [5] = '{23'd3, 23'd11, 23'd20, 23'd39, 23'd0};

  initial begin
    bit acc;
    int ptr;
    idle();
    bus.out_ready_i = 1'b1;

    // Reset asserted before any clock edge
    #1 rst = 1'b1;
    bus.in_valid_i = 1'b1;
    #1;
    chk("rst_out_valid", {22'd0, bus.out_valid_o}, 23'd0);
    chk("rst_in_ready", {22'd0, bus.in_ready_o}, 23'd0);
    chk("rst_c", bus.c_o, 23'd0);
    chk("rst_err", {22'd0, bus.err_o}, 23'd0);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {22'd0, bus.in_ready_o}, 23'd1);

    // Modular add, q=40, back to back
    send(1'b0, 23'd20, 23'd3,  23'd40, 23'd23, 1'b0);
    send(1'b0, 23'd20, 23'd21, 23'd40, 23'd1,  1'b0);
    send(1'b0, 23'd39, 23'd39, 23'd40, 23'd38, 1'b0);
    // Modular subtract, q=40
    send(1'b1, 23'd3,  23'd20, 23'd40, 23'd23, 1'b0);
    send(1'b1, 23'd20, 23'd3,  23'd40, 23'd17, 1'b0);
    send(1'b1, 23'd0,  23'd0,  23'd40, 23'd0,  1'b0);
    send(1'b1, 23'd0,  23'd39, 23'd40, 23'd1,  1'b0);
    // Full-width modulus
    send(1'b0, 23'd8380416, 23'd1,       23'd8380417, 23'd0,       1'b0);
    send(1'b1, 23'd0,       23'd8380416, 23'd8380417, 23'd1,       1'b0);
    send(1'b0, 23'd8380416, 23'd8380416, 23'd8380417, 23'd8380415, 1'b0);
    // Out-of-range operand flags only its own beat
    send(1'b0, 23'd45, 23'd3, 23'd40, 23'd8, 1'b1);
    send(1'b0, 23'd1,  23'd1, 23'd40, 23'd2, 1'b0);
    drain();

    // Backpressure: consumer stalls for cycles 3..6 of a 5-beat stream
    lat_chk = 1'b0;
    ptr = 0;
    for (int j = 0; j < 30 && !(ptr == 5 && exp_c_q.size() == 0); j++) begin
      bus.out_ready_i = !(j >= 3 && j <= 6);
      if (ptr < 5) set_beat(bp_op[ptr], bp_a[ptr], bp_b[ptr], 23'd40, bp_c[ptr], 1'b0);
      else idle();
      step(acc);
      if (acc) ptr++;
    end
    chk("bp_accepted", W'(ptr), W'(5));
    drain();

    // Reset with two beats in flight
    lat_chk = 1'b1;
    send(1'b0, 23'd1, 23'd1, 23'd40, 23'd2, 1'b0);
    send(1'b0, 23'd2, 23'd2, 23'd40, 23'd4, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {22'd0, bus.out_valid_o}, 23'd0);
    chk("mid_rst_c", bus.c_o, 23'd0);
    chk("mid_rst_in_ready", {22'd0, bus.in_ready_o}, 23'd0);
    exp_c_q.delete();
    exp_e_q.delete();
    exp_t_q.delete();
    occ = 0;
    held_v = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_hold_valid", {22'd0, bus.out_valid_o}, 23'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(acc);
      chk("no_stale", {22'd0, bus.out_valid_o}, 23'd0);
    end
    send(1'b0, 23'd1, 23'd2, 23'd40, 23'd3, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
